// File: rtl/trace_event_capture.sv
// Captures l.nop trace events (K != 0) with the current r3 value into a FIFO and tracks the exit event.
// Optional macro OPTIMSOC_TRACE_EVENT_PC_EN stores the event PC per entry; when it is undefined, event_pc reads as zero.
module trace_event_capture #(
    parameter int unsigned ID         = 0,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_sys,
    input  logic        trace_enable,
    input  logic [31:0] trace_insn,
    input  logic [31:0] trace_pc,
    input  logic        trace_wben,
    input  logic [4:0]  trace_wbreg,
    input  logic [31:0] trace_wbdata,
    output logic        event_valid,
    input  logic        event_ready,
    output logic [15:0] event_code,
    output logic [31:0] event_value,
    output logic [31:0] event_pc,
    output logic [15:0] event_id,
    output logic        termination,
    output logic [7:0]  overflow_cnt
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef OPTIMSOC_TRACE_EVENT_PC_EN
    typedef struct packed {
        logic [15:0] code;
        logic [31:0] value;
        logic [31:0] pc;
    } entry_t;
`else
    typedef struct packed {
        logic [15:0] code;
        logic [31:0] value;
    } entry_t;
`endif

    typedef enum logic [1:0] {
        ST_RUN          = 2'd0,
        ST_EXIT_PENDING = 2'd1,
        ST_DONE         = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    ovf_q, ovf_d;
    logic          valid_q, valid_d;
    entry_t        mem_q [FIFO_DEPTH];

    logic   detect_c;
    logic   accept_c;
    logic   full_c;
    logic   pop_c;
    logic   push_c;
    entry_t wdata_c;

    // Next-state logic for shadow, FIFO bookkeeping, drop counter and exit FSM
    always_comb begin
        shadow_d = shadow_q;
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        detect_c = trace_enable && (trace_insn[31:24] == 8'h15) && (trace_insn[15:0] != 16'h0);
        accept_c = detect_c && (state_q == ST_RUN);
        full_c   = (count_q == FULL_CNT);
        pop_c    = valid_q && event_ready;
        push_c   = accept_c && (!full_c || pop_c);

        wdata_c       = '0;
        wdata_c.code  = trace_insn[15:0];
        wdata_c.value = shadow_q;
`ifdef OPTIMSOC_TRACE_EVENT_PC_EN
        wdata_c.pc    = trace_pc;
`endif

        if (trace_enable && trace_wben && (trace_wbreg == 5'd3)) begin
            shadow_d = trace_wbdata;
        end

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (accept_c && !push_c && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end

        // No pushes follow the exit event, so it is always the last entry left
        case (state_q)
            ST_RUN: begin
                if (push_c && (trace_insn[15:0] == 16'd1)) begin
                    state_d = ST_EXIT_PENDING;
                end
            end
            ST_EXIT_PENDING: begin
                if (pop_c && (count_q == CW'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RUN;
        endcase

        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            state_q  <= ST_RUN;
            shadow_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    // Storage needs no reset: contents are only observed while valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wdata_c;
        end
    end

    assign event_valid  = valid_q;
    assign event_code   = mem_q[rd_ptr_q].code;
    assign event_value  = mem_q[rd_ptr_q].value;
    assign event_id     = 16'(ID);
    assign termination  = (state_q == ST_DONE);
    assign overflow_cnt = ovf_q;

`ifdef OPTIMSOC_TRACE_EVENT_PC_EN
    assign event_pc = mem_q[rd_ptr_q].pc;
    logic unused_bits_c;
    assign unused_bits_c = ^trace_insn[23:16];
`else
    assign event_pc = 32'h0;
    logic unused_bits_c;
    assign unused_bits_c = ^{trace_insn[23:16], trace_pc};
`endif

endmodule

// File: tb/tb_trace_event_capture.sv
// Self-checking bench for trace_event_capture: directed scenarios plus random traffic against a queue model.
module tb_trace_event_capture;

    localparam int unsigned DEPTH  = 8;
    localparam logic [15:0] TB_ID  = 16'd7;

    logic        clk;
    logic        rst_sys;
    logic        trace_enable;
    logic [31:0] trace_insn;
    logic [31:0] trace_pc;
    logic        trace_wben;
    logic [4:0]  trace_wbreg;
    logic [31:0] trace_wbdata;
    logic        event_valid;
    logic        event_ready;
    logic [15:0] event_code;
    logic [31:0] event_value;
    logic [31:0] event_pc;
    logic [15:0] event_id;
    logic        termination;
    logic [7:0]  overflow_cnt;

    int checks = 0;
    int errors = 0;

    trace_event_capture #(.ID(int'(TB_ID)), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_sys      (rst_sys),
        .trace_enable (trace_enable),
        .trace_insn   (trace_insn),
        .trace_pc     (trace_pc),
        .trace_wben   (trace_wben),
        .trace_wbreg  (trace_wbreg),
        .trace_wbdata (trace_wbdata),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_code   (event_code),
        .event_value  (event_value),
        .event_pc     (event_pc),
        .event_id     (event_id),
        .termination  (termination),
        .overflow_cnt (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: event list, r3 value, drop count, exit progress
    typedef struct {
        logic [15:0] code;
        logic [31:0] value;
        logic [31:0] pc;
    } ev_t;

    ev_t         m_q[$];
    logic [31:0] m_r3;
    int          m_drops;
    bit          m_exit_seen;
    bit          m_done;

    function automatic logic [31:0] exp_pc(input logic [31:0] pc);
`ifdef OPTIMSOC_TRACE_EVENT_PC_EN
        return pc;
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_r3        = 32'h0;
        m_drops     = 0;
        m_exit_seen = 1'b0;
        m_done      = 1'b0;
    endtask

    task automatic set_in(input logic en, input logic [31:0] insn, input logic [31:0] pc,
                          input logic wben, input logic [4:0] wreg, input logic [31:0] wdata);
        trace_enable = en;
        trace_insn   = insn;
        trace_pc     = pc;
        trace_wben   = wben;
        trace_wbreg  = wreg;
        trace_wbdata = wdata;
    endtask

    task automatic idle();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // One clock: the model applies the same inputs the DUT saw at the edge
    task automatic tick();
        bit  pop;
        bit  det;
        ev_t e;
        ev_t gone;
        pop = (m_q.size() != 0) && event_ready;
        det = trace_enable && (trace_insn[31:24] == 8'h15) && (trace_insn[15:0] != 16'h0);
        e.code  = trace_insn[15:0];
        e.value = m_r3;
        e.pc    = exp_pc(trace_pc);
        @(posedge clk);
        if (pop) begin
            gone = m_q.pop_front();
            if (gone.code == 16'd1) m_done = 1'b1;
        end
        if (det && !m_exit_seen) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(e);
                if (e.code == 16'd1) m_exit_seen = 1'b1;
            end else if (m_drops < 255) begin
                m_drops++;
            end
        end
        if (trace_enable && trace_wben && trace_wbreg == 5'd3) m_r3 = trace_wbdata;
        #1;
    endtask

    task automatic test_reset();
        rst_sys     = 1'b1;
        event_ready = 1'b0;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", event_valid); end
        checks++; if (overflow_cnt !== 8'h0) begin errors++; $display("FAIL reset_ovf got %0h want 0", overflow_cnt); end
        checks++; if (termination !== 1'b0) begin errors++; $display("FAIL reset_term got %0b want 0", termination); end
        rst_sys = 1'b0;
        tick();
    endtask

    task automatic test_r3_capture();
        event_ready = 1'b0;
        set_in(1'b1, 32'h9C60_0041, 32'h0FC, 1'b1, 5'd3, 32'h41);
        tick();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL r3_write_no_event got %0b want 0", event_valid); end
        set_in(1'b1, 32'h1500_0004, 32'h100, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        checks++; if (event_valid !== 1'b1) begin errors++; $display("FAIL r3_valid got %0b want 1", event_valid); end
        checks++; if (event_code !== 16'h4) begin errors++; $display("FAIL r3_code got %0h want 4", event_code); end
        checks++; if (event_value !== 32'h41) begin errors++; $display("FAIL r3_value got %0h want 41", event_value); end
        checks++; if (event_pc !== exp_pc(32'h100)) begin errors++; $display("FAIL r3_pc got %0h want %0h", event_pc, exp_pc(32'h100)); end
        checks++; if (event_id !== TB_ID) begin errors++; $display("FAIL r3_id got %0h want %0h", event_id, TB_ID); end
        tick();
        checks++; if (event_value !== 32'h41) begin errors++; $display("FAIL r3_hold got %0h want 41", event_value); end
        event_ready = 1'b1;
        tick();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL r3_drained got %0b want 0", event_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] want_val;
        event_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'h1500_0002, 32'h300 + 32'(4 * i), 1'b1, 5'd3, 32'h1000 + 32'(i));
            tick();
        end
        idle();
        tick();
        checks++; if (overflow_cnt !== 8'd2) begin errors++; $display("FAIL ovf_count got %0d want 2", overflow_cnt); end
        event_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            want_val = (i == 0) ? 32'h41 : 32'h1000 + 32'(i - 1);
            checks++;
            if (event_valid !== 1'b1 || event_code !== 16'h2 || event_value !== want_val
                || event_pc !== exp_pc(32'h300 + 32'(4 * i))) begin
                errors++;
                $display("FAIL ovf_drain_%0d got v=%0b c=%0h val=%0h pc=%0h want v=1 c=2 val=%0h pc=%0h",
                         i, event_valid, event_code, event_value, event_pc, want_val, exp_pc(32'h300 + 32'(4 * i)));
            end
            tick();
        end
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b want 0", event_valid); end
    endtask

    task automatic test_full_pop();
        int n;
        event_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 32'h1500_0002, 32'h400 + 32'(i), 1'b0, 5'd0, 32'h0);
            tick();
        end
        event_ready = 1'b1;
        set_in(1'b1, 32'h1500_0002, 32'h500, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        checks++; if (overflow_cnt !== 8'd2) begin errors++; $display("FAIL fullpop_ovf got %0d want 2", overflow_cnt); end
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (event_valid === 1'b1) n++;
            tick();
        end
        checks++; if (n != 8) begin errors++; $display("FAIL fullpop_count got %0d want 8", n); end
    endtask

    task automatic test_non_events();
        event_ready = 1'b0;
        set_in(1'b1, 32'h1500_0000, 32'h600, 1'b0, 5'd0, 32'h0);
        tick();
        set_in(1'b1, 32'hE000_0001, 32'h604, 1'b0, 5'd0, 32'h0);
        tick();
        set_in(1'b0, 32'h1500_0003, 32'h608, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        tick();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL nonevent_valid got %0b want 0", event_valid); end
        checks++; if (overflow_cnt !== 8'd2) begin errors++; $display("FAIL nonevent_ovf got %0d want 2", overflow_cnt); end
    endtask

    task automatic test_random(input int cycles);
        logic [31:0] insn;
        logic [15:0] k;
        logic [4:0]  wreg;
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(0, 9) < 4) begin
                k    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(2, 65535));
                insn = {8'h15, 8'($urandom), k};
            end else begin
                insn = $urandom;
                if (insn[31:24] == 8'h15) insn[31:24] = 8'h16;
            end
            wreg = ($urandom_range(0, 1) == 1) ? 5'd3 : 5'($urandom);
            set_in($urandom_range(0, 4) != 0, insn, $urandom, 1'($urandom), wreg, $urandom);
            event_ready = ($urandom_range(0, 2) != 0);
            tick();
            checks++;
            if (event_valid !== (m_q.size() != 0)) begin
                errors++; $display("FAIL rand_valid cyc %0d got %0b want %0b", c, event_valid, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if (event_code !== m_q[0].code || event_value !== m_q[0].value || event_pc !== m_q[0].pc) begin
                    errors++;
                    $display("FAIL rand_head cyc %0d got c=%0h v=%0h pc=%0h want c=%0h v=%0h pc=%0h",
                             c, event_code, event_value, event_pc, m_q[0].code, m_q[0].value, m_q[0].pc);
                end
            end
            checks++;
            if (overflow_cnt !== 8'(m_drops) || termination !== m_done) begin
                errors++;
                $display("FAIL rand_status cyc %0d got ovf=%0d term=%0b want ovf=%0d term=%0b",
                         c, overflow_cnt, termination, m_drops, m_done);
            end
        end
        idle();
        event_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_exit();
        int ovf_before;
        ovf_before  = m_drops;
        event_ready = 1'b0;
        set_in(1'b1, 32'h9C60_0000, 32'h700, 1'b1, 5'd3, 32'h0);
        tick();
        set_in(1'b1, 32'h1500_0001, 32'h704, 1'b0, 5'd0, 32'h0);
        tick();
        set_in(1'b1, 32'h1500_0004, 32'h708, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        tick();
        checks++;
        if (event_valid !== 1'b1 || event_code !== 16'h1 || event_value !== 32'h0) begin
            errors++; $display("FAIL exit_head got v=%0b c=%0h val=%0h want v=1 c=1 val=0", event_valid, event_code, event_value);
        end
        checks++; if (termination !== 1'b0) begin errors++; $display("FAIL exit_term_early got %0b want 0", termination); end
        event_ready = 1'b1;
        tick();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL exit_only_one got %0b want 0", event_valid); end
        checks++; if (termination !== 1'b1) begin errors++; $display("FAIL exit_term got %0b want 1", termination); end
        set_in(1'b1, 32'h1500_0002, 32'h70C, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        tick();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL done_ignore got %0b want 0", event_valid); end
        checks++;
        if (overflow_cnt !== 8'(ovf_before) || termination !== 1'b1) begin
            errors++; $display("FAIL done_status got ovf=%0d term=%0b want ovf=%0d term=1", overflow_cnt, termination, ovf_before);
        end
    endtask

    task automatic test_reset_mid();
        rst_sys = 1'b1;
        model_reset();
        #2;
        checks++; if (termination !== 1'b0) begin errors++; $display("FAIL rstmid_term got %0b want 0", termination); end
        @(posedge clk);
        #1;
        rst_sys     = 1'b0;
        event_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h1500_0009, 32'h800 + 32'(i), 1'b0, 5'd0, 32'h0);
            tick();
        end
        idle();
        checks++; if (event_valid !== 1'b1) begin errors++; $display("FAIL rstmid_queued got %0b want 1", event_valid); end
        rst_sys = 1'b1;
        model_reset();
        #2;
        checks++;
        if (event_valid !== 1'b0 || overflow_cnt !== 8'h0 || termination !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear got v=%0b ovf=%0d term=%0b want 0 0 0", event_valid, overflow_cnt, termination);
        end
        @(posedge clk);
        #1;
        rst_sys = 1'b0;
        set_in(1'b1, 32'h1500_0005, 32'h900, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        checks++;
        if (event_valid !== 1'b1 || event_code !== 16'h5 || event_value !== 32'h0 || event_pc !== exp_pc(32'h900)) begin
            errors++; $display("FAIL rstmid_new got v=%0b c=%0h val=%0h pc=%0h want v=1 c=5 val=0 pc=%0h",
                               event_valid, event_code, event_value, event_pc, exp_pc(32'h900));
        end
        event_ready = 1'b1;
        tick();
    endtask

    task automatic test_ovf_saturate();
        event_ready = 1'b0;
        for (int i = 0; i < 270; i++) begin
            set_in(1'b1, 32'h1500_0002, 32'($urandom), 1'b0, 5'd0, 32'h0);
            tick();
        end
        idle();
        checks++; if (overflow_cnt !== 8'hFF) begin errors++; $display("FAIL ovf_sat got %0h want ff", overflow_cnt); end
        checks++; if (overflow_cnt !== 8'(m_drops)) begin errors++; $display("FAIL ovf_sat_model got %0d want %0d", overflow_cnt, m_drops); end
    endtask

    initial begin
        test_reset();
        test_r3_capture();
        test_overflow();
        test_full_pop();
        test_non_events();
        test_random(400);
        test_exit();
        test_reset_mid();
        test_random(200);
        test_ovf_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_event_capture.md
TRACE_EVENT_CAPTURE -- requirements
Module: trace_event_capture

Interface
REQ-001 SHALL have parameter ID, default 0, core index copied into every event.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries; legal values are powers of two from 2 to 64.
REQ-003 SHALL have port clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_sys  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port trace_enable  input  1  one instruction retired this cycle.
REQ-006 SHALL have port trace_insn  input  32  retired instruction word.
REQ-007 SHALL have port trace_pc  input  32  retired instruction PC.
REQ-008 SHALL have port trace_wben  input  1  retired instruction writes a GPR.
REQ-009 SHALL have port trace_wbreg  input  5  writeback register index.
REQ-010 SHALL have port trace_wbdata  input  32  writeback data.
REQ-011 SHALL have port event_valid  output  1  FIFO head holds an event.
REQ-012 SHALL have port event_ready  input  1  consumer accepts the head event.
REQ-013 SHALL have port event_code  output  16  l.nop immediate K of the head event.
REQ-014 SHALL have port event_value  output  32  r3 value at the time of the head event.
REQ-015 SHALL have port event_pc  output  32  PC of the head event.
REQ-016 SHALL have port event_id  output  16  ID of the head event.
REQ-017 SHALL have port termination  output  1  sticky; the exit event has been consumed.
REQ-018 SHALL have port overflow_cnt  output  8  number of events dropped, saturating.

Function
REQ-019 SHALL maintain a 32-bit r3 shadow register: when trace_enable, trace_wben and trace_wbreg==3 are all high, the shadow SHALL load trace_wbdata.
REQ-020 SHALL detect an event when trace_enable=1, trace_insn[31:24]==8'h15 and trace_insn[15:0]!=0; K is trace_insn[15:0].
REQ-021 SHALL capture event_value from the shadow register as it stands before that cycle's update.
REQ-022 SHALL push {K, shadow, trace_pc, ID} into the FIFO in the detect cycle; event_valid SHALL rise no earlier than the next cycle, with no combinational bypass.
REQ-023 SHALL pop the head entry on a cycle where event_valid and event_ready are both high.
REQ-024 SHALL hold the event_* outputs stable while event_valid=1 and event_ready=0.
REQ-025 SHALL drop a detected event when the FIFO is full and no pop occurs that cycle; overflow_cnt SHALL then increment, saturating at 8'hFF.
REQ-026 SHALL accept the push when the FIFO is full and a pop occurs in the same cycle; occupancy stays FIFO_DEPTH.
REQ-027 SHALL wrap read and write pointers modulo FIFO_DEPTH; occupancy SHALL be tracked in log2(FIFO_DEPTH)+1 bits.
REQ-028 SHALL run a state machine with states RUN, EXIT_PENDING and DONE: RUN moves to EXIT_PENDING when an event with K==1 is pushed; EXIT_PENDING moves to DONE when that event is popped; DONE SHALL hold until reset.
REQ-029 SHALL assert termination only in DONE.
REQ-030 SHALL ignore all detected events in EXIT_PENDING and DONE: no push, and no overflow_cnt increment.
REQ-031 SHALL keep updating the r3 shadow in every state.

Reset
REQ-032 SHALL, while rst_sys=1 and asynchronously, clear the shadow, FIFO pointers, occupancy and overflow_cnt, enter state RUN, and drive event_valid=0 and termination=0.
REQ-033 SHALL discard all FIFO contents on reset assertion mid-operation; the event_* data outputs are don't-care while event_valid=0.

Configuration
REQ-034 SHALL, with OPTIMSOC_TRACE_EVENT_PC_EN defined, store trace_pc per entry and drive it on event_pc.
REQ-035 SHALL, without OPTIMSOC_TRACE_EVENT_PC_EN, omit PC storage from the FIFO and drive event_pc constant 32'h0; all other behaviour is unchanged.

Verification
REQ-036 SHALL cover r3 capture: retire a write of r3=0x41, then l.nop 0x4 at PC 0x100 -> one cycle later event_valid=1, code=0x4, value=0x41, pc=0x100 (0 without the macro).
REQ-037 SHALL cover overflow: with event_ready=0 and FIFO_DEPTH=8, issue 10 l.nop 0x2 -> 8 events held, overflow_cnt=2, then drained in order.
REQ-038 SHALL cover full with simultaneous pop: FIFO full, event_ready=1 and a new l.nop 0x2 in the same cycle -> push accepted, overflow_cnt unchanged.
REQ-039 SHALL cover exit: l.nop 0x1 with r3=0, followed by l.nop 0x4 -> only the exit event is queued; termination=1 the cycle after the exit event is popped.
REQ-040 SHALL cover reset mid-operation: 3 events queued, pulse rst_sys -> event_valid=0, overflow_cnt=0, termination=0 immediately, and new events are captured afterwards.
REQ-041 SHALL cover non-events: plain l.nop 0x0 and a non-nop instruction with insn[15:0]=0x1 -> no event produced.
